// File: rtl/joy_serial_pkg.sv
// Shared definitions for the 24-slot joystick serial chain.
// Contents:
//   NBITS / CNT_W  - slots per frame and width of the shift counter
//   joy_state_e    - FSM encodings IDLE/LOAD/SHIFT/DRAINED
//   SLOT_P2        - bit s set when slot s carries a player-2 input
//   SLOT_IDX       - 4-bit joystick bit index per slot, slot 0 in the LSBs
//   slot_vector()  - packs joy1/joy2 into chain order, slot 0 at bit 0
package joy_serial_pkg;

    localparam int NBITS = 24;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DRAINED = 2'd3
    } joy_state_e;

    // Slots 0-7 are player 1, 8-15 player 2, 16-19 player 2 extras,
    // 20-23 player 1 extras.
    localparam logic [NBITS-1:0] SLOT_P2 = 24'h0F_FF00;

    // Per slot, MSB nibble = slot 23:
    //   start,fire3,fire2,fire1,right,left,down,up = 8,6,5,4,3,2,1,0
    //   select,test/service,coin,fire4            = 10,11,9,7
    localparam logic [NBITS*4-1:0] SLOT_IDX = 96'h79BA_79BA_0123_4568_0123_4568;

    function automatic logic [NBITS-1:0] slot_vector(input logic [11:0] j1,
                                                      input logic [11:0] j2);
        logic [NBITS-1:0] v;
        logic [3:0]       idx;
        v = '1;
        for (int s = 0; s < NBITS; s++) begin
            idx  = SLOT_IDX[s*4 +: 4];
            v[s] = SLOT_P2[s] ? j2[idx] : j1[idx];
        end
        return v;
    endfunction

endpackage

// File: rtl/joy_sync_edge.sv
// Multi-flop synchronizer for an asynchronous master pin, plus a rise
// detector on the synchronized level.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   din        - asynchronous input pin
//   level      - synchronized level (STAGES flops after the pin)
//   rise       - one-clk pulse when level goes 0 -> 1
module joy_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/joy_serializer.sv
// Slave-side emulation of a 24-bit 74HC165-style joystick chain.
// While joy_load is low the chain transparently captures joy1/joy2; with
// joy_load high each rising joy_clk shifts one slot toward joy_data.
// Ports:
//   clk          - system clock, > 8x joy_clk
//   clock_locked - async active-low reset
//   joy_clk      - master shift clock (async)
//   joy_load     - master active-low parallel load (async)
//   joy_data     - serial data to master, registered
//   joy1, joy2   - active-low player vectors
//   shift_count  - shifts since last load, saturates at NBITS
//   frame_done   - one-clk pulse on reaching NBITS shifts
module joy_serializer
    import joy_serial_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,   // must be >= 2
    parameter logic SER_FILL    = 1'b1
) (
    input  logic             clk,
    input  logic             clock_locked,
    input  logic             joy_clk,
    input  logic             joy_load,
    output logic             joy_data,
    input  logic [11:0]      joy1,
    input  logic [11:0]      joy2,
    output logic [CNT_W-1:0] shift_count,
    output logic             frame_done
);

    logic clk_lvl, clk_rise;
    logic load_lvl, load_rise;

    joy_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk   (clk),
        .rst_n (clock_locked),
        .din   (joy_clk),
        .level (clk_lvl),
        .rise  (clk_rise)
    );

    joy_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
        .clk   (clk),
        .rst_n (clock_locked),
        .din   (joy_load),
        .level (load_lvl),
        .rise  (load_rise)
    );

    joy_state_e       state_q, state_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fd_q, fd_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        if (!load_lvl) begin
            // Level-transparent capture; also overrides a coincident clk_rise.
            state_d = ST_LOAD;
            sr_d    = slot_vector(joy1, joy2);
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: if (load_rise) state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_d  = {SER_FILL, sr_q[NBITS-1:1]};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(NBITS - 1)) begin
                            state_d = ST_DRAINED;
                            fd_d    = 1'b1;
                        end
                    end
                end
                ST_DRAINED: begin
                    // Keeps shifting so the master sees the cascade fill.
                    if (clk_rise) sr_d = {SER_FILL, sr_q[NBITS-1:1]};
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clock_locked) begin
        if (!clock_locked) begin
            state_q <= ST_IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
        end
    end

    // joy_data lags the pin edge by SYNC_STAGES+1 clks, giving master hold time.
    assign joy_data    = sr_q[0];
    assign shift_count = cnt_q;
    assign frame_done  = fd_q;

    // clk_lvl is only needed inside the edge detector.
    logic unused_ok;
    assign unused_ok = clk_lvl;

endmodule

// File: tb/tb_joy_serializer.sv
module tb_joy_serializer;

    logic        clk = 1'b0;
    logic        clock_locked = 1'b0;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic        joy_data;
    logic [11:0] joy1 = 12'hFFF;
    logic [11:0] joy2 = 12'hFFF;
    logic [4:0]  shift_count;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int fd_pulses = 0;
    int fd_high   = 0;
    logic fd_prev = 1'b0;

    joy_serializer dut (
        .clk          (clk),
        .clock_locked (clock_locked),
        .joy_clk      (joy_clk),
        .joy_load     (joy_load),
        .joy_data     (joy_data),
        .joy1         (joy1),
        .joy2         (joy2),
        .shift_count  (shift_count),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clock_locked && frame_done) fd_high++;
        if (clock_locked && frame_done && !fd_prev) fd_pulses++;
        fd_prev = frame_done;
    end

    // Expected chain contents by name, slot 0 first.
    function automatic logic [23:0] exp_frame(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] e;
        e[0]  = a[8];  e[1]  = a[6];  e[2]  = a[5];  e[3]  = a[4];
        e[4]  = a[3];  e[5]  = a[2];  e[6]  = a[1];  e[7]  = a[0];
        e[8]  = b[8];  e[9]  = b[6];  e[10] = b[5];  e[11] = b[4];
        e[12] = b[3];  e[13] = b[2];  e[14] = b[1];  e[15] = b[0];
        e[16] = b[10]; e[17] = b[11]; e[18] = b[9];  e[19] = b[7];
        e[20] = a[10]; e[21] = a[11]; e[22] = a[9];  e[23] = a[7];
        return e;
    endfunction

    // Decoder view: recover {joy2, joy1} from the 24 samples.
    function automatic logic [23:0] decode(input logic [23:0] s);
        logic [11:0] a, b;
        a[8] = s[0];  a[6] = s[1];  a[5] = s[2];  a[4] = s[3];
        a[3] = s[4];  a[2] = s[5];  a[1] = s[6];  a[0] = s[7];
        b[8] = s[8];  b[6] = s[9];  b[5] = s[10]; b[4] = s[11];
        b[3] = s[12]; b[2] = s[13]; b[1] = s[14]; b[0] = s[15];
        b[10] = s[16]; b[11] = s[17]; b[9] = s[18]; b[7] = s[19];
        a[10] = s[20]; a[11] = s[21]; a[9] = s[22]; a[7] = s[23];
        return {b, a};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Load low for one joy_clk period, then release; checks the load state.
    task automatic do_load(input logic [11:0] a, input logic [11:0] b, input int half,
                           input bit scramble);
        logic [23:0] e;
        e = exp_frame(a, b);
        joy1 = a; joy2 = b;
        joy_load = 1'b0;
        wait_clks(2 * half);
        checks++;
        if (shift_count !== 5'd0) begin
            errors++;
            $display("FAIL load_count: got %0d want 0", shift_count);
        end
        checks++;
        if (joy_data !== e[0]) begin
            errors++;
            $display("FAIL load_slot0: got %b want %b", joy_data, e[0]);
        end
        joy_load = 1'b1;
        wait_clks(8);
        if (scramble) begin
            joy1 = 12'($urandom);
            joy2 = 12'($urandom);
        end
        wait_clks(half - 8);
    endtask

    // Master samples joy_data at each rising joy_clk, pre-shift.
    task automatic do_rises(input int n, input int half, output logic [31:0] s,
                            output int fd_before_last);
        s = '1;
        fd_before_last = fd_pulses;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) fd_before_last = fd_pulses;
            s[i] = joy_data;
            joy_clk = 1'b1;
            wait_clks(half);
            joy_clk = 1'b0;
            wait_clks(half);
        end
    endtask

    task automatic check_frame(input string name, input logic [11:0] a, input logic [11:0] b,
                               input logic [31:0] s);
        logic [23:0] e;
        e = exp_frame(a, b);
        checks++;
        if (s[23:0] !== e) begin
            errors++;
            $display("FAIL %s: got %06h want %06h", name, s[23:0], e);
        end
    endtask

    task automatic test_reset();
        clock_locked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 3 == 0) joy_clk = ~joy_clk;
            if (i % 5 == 0) joy_load = ~joy_load;
            checks++;
            if (joy_data !== 1'b1 || shift_count !== 5'd0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: data=%b cnt=%0d fd=%b want 1/0/0",
                         joy_data, shift_count, frame_done);
            end
        end
        joy_clk = 1'b0; joy_load = 1'b1;
        wait_clks(4);
        clock_locked = 1'b1;
        wait_clks(4);
        // IDLE ignores rises before the first load.
        for (int i = 0; i < 3; i++) begin
            joy_clk = 1'b1; wait_clks(16);
            joy_clk = 1'b0; wait_clks(16);
            checks++;
            if (joy_data !== 1'b1 || shift_count !== 5'd0) begin
                errors++;
                $display("FAIL idle_rise: data=%b cnt=%0d want 1/0", joy_data, shift_count);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] s;
        int p0, h0, fdb;
        p0 = fd_pulses; h0 = fd_high;
        do_load(12'hEFF, 12'hFFF, 16, 1'b0);
        do_rises(24, 16, s, fdb);
        check_frame("frame_1p_start", 12'hEFF, 12'hFFF, s);
        checks++;
        if (fdb != p0) begin
            errors++;
            $display("FAIL fd_early: pulses before rise 24 = %0d want 0", fdb - p0);
        end
        checks++;
        if (fd_pulses - p0 != 1 || fd_high - h0 != 1) begin
            errors++;
            $display("FAIL fd_single: pulses=%0d high=%0d want 1/1", fd_pulses - p0, fd_high - h0);
        end
        checks++;
        if (shift_count !== 5'd24) begin
            errors++;
            $display("FAIL count_24: got %0d want 24", shift_count);
        end
    endtask

    task automatic test_slot_map();
        logic [31:0] s;
        int fdb;
        do_load(12'hFFF, 12'hFFE, 16, 1'b0);
        do_rises(24, 16, s, fdb);
        check_frame("slot15_2p_up", 12'hFFF, 12'hFFE, s);
        do_load(12'h7FF, 12'hFFF, 16, 1'b0);
        do_rises(24, 16, s, fdb);
        check_frame("slot21_service", 12'h7FF, 12'hFFF, s);
    endtask

    task automatic test_abort();
        logic [31:0] s;
        int p0, fdb;
        p0 = fd_pulses;
        do_load(12'h5A5, 12'hA5A, 16, 1'b0);
        do_rises(10, 16, s, fdb);
        checks++;
        if (shift_count !== 5'd10) begin
            errors++;
            $display("FAIL abort_pre: got %0d want 10", shift_count);
        end
        do_load(12'h3C3, 12'hC3C, 16, 1'b0);
        checks++;
        if (fd_pulses != p0) begin
            errors++;
            $display("FAIL abort_fd: pulses=%0d want 0", fd_pulses - p0);
        end
        do_rises(24, 16, s, fdb);
        check_frame("abort_next", 12'h3C3, 12'hC3C, s);
    endtask

    task automatic test_drain();
        logic [31:0] s;
        int p0, fdb;
        do_load(12'h000, 12'h000, 16, 1'b0);
        p0 = fd_pulses;
        do_rises(30, 16, s, fdb);
        check_frame("drain_body", 12'h000, 12'h000, s);
        checks++;
        if (s[29:24] !== 6'b111111) begin
            errors++;
            $display("FAIL drain_fill: got %b want 111111", s[29:24]);
        end
        checks++;
        if (shift_count !== 5'd24) begin
            errors++;
            $display("FAIL drain_count: got %0d want 24", shift_count);
        end
        checks++;
        if (fd_pulses - p0 != 1) begin
            errors++;
            $display("FAIL drain_fd: pulses=%0d want 1", fd_pulses - p0);
        end
    endtask

    task automatic test_load_race();
        logic [31:0] s;
        logic [23:0] e;
        int fdb;
        do_load(12'hFFF, 12'hFFF, 16, 1'b0);
        do_rises(5, 16, s, fdb);
        joy1 = 12'h9E1; joy2 = 12'h1E9;
        e = exp_frame(12'h9E1, 12'h1E9);
        // Load fall and clock rise reach the synchronizers together.
        joy_load = 1'b0; joy_clk = 1'b1;
        wait_clks(16);
        checks++;
        if (shift_count !== 5'd0) begin
            errors++;
            $display("FAIL race_count: got %0d want 0", shift_count);
        end
        checks++;
        if (joy_data !== e[0]) begin
            errors++;
            $display("FAIL race_slot0: got %b want %b", joy_data, e[0]);
        end
        joy_clk = 1'b0; wait_clks(16);
        joy_load = 1'b1; wait_clks(16);
        do_rises(24, 16, s, fdb);
        check_frame("race_frame", 12'h9E1, 12'h1E9, s);
    endtask

    task automatic test_random();
        logic [31:0] s;
        logic [11:0] a, b;
        logic [23:0] d;
        int fdb;
        for (int f = 0; f < 100; f++) begin
            a = 12'($urandom); b = 12'($urandom);
            do_load(a, b, 8, 1'b1);
            do_rises(24, 8, s, fdb);
            d = decode(s[23:0]);
            checks++;
            if (d !== {b, a}) begin
                errors++;
                $display("FAIL rand_frame%0d: got j1=%03h j2=%03h want j1=%03h j2=%03h",
                         f, d[11:0], d[23:12], a, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_slot_map();
        test_abort();
        test_drain();
        test_load_race();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
